// File: rtl/td4_pkg.sv
// td4_pkg: shared opcode encodings and run-control FSM states for the TD4 core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: OP_* 4-bit opcode values (instruction bits [N+3:N]), state_t encoding.
package td4_pkg;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_A  = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_B  = 4'b0111;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_IM = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

endpackage

// File: rtl/td4_alu.sv
// td4_alu: N-bit adder with carry-out, used for every data-bus result.
// Latency: combinational.
// Backpressure: none.
// Ports: src_i, imm_i (N) -> sum_o (N, wraps mod 2^N), co_o (carry-out).
module td4_alu #(
  parameter int N = 4
) (
  input  logic [N-1:0] src_i,
  input  logic [N-1:0] imm_i,
  output logic [N-1:0] sum_o,
  output logic         co_o
);

  always_comb begin
    {co_o, sum_o} = {1'b0, src_i} + {1'b0, imm_i};
  end

endmodule

// File: rtl/td4_exec_unit.sv
// td4_exec_unit: TD4 decode/execute stage; drives data bus, next PC and register load selects.
// Latency: decode combinational from op_i; registers capture on the next edge (1 cycle to Q).
// Backpressure: none; clr_i forces all load selects inactive without a clock.
// Ports: clk_i, clr_i (async active-high), op_i (4+N), pc_i/reg_a_i/reg_b_i/in_port_i (N);
//        d_o, pc_d_o (N), cs_a_o/cs_b_o/cs_out_o/cs_pc_o (active-low), carry_o, halted_o.
// Config: define HALT_DETECT_EN to stop in ST_HALT on a taken self-jump; otherwise halted_o is 0.
module td4_exec_unit
  import td4_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk_i,
  input  logic           clr_i,
  input  logic [N+3:0]   op_i,
  input  logic [N-1:0]   pc_i,
  input  logic [N-1:0]   reg_a_i,
  input  logic [N-1:0]   reg_b_i,
  input  logic [N-1:0]   in_port_i,
  output logic [N-1:0]   d_o,
  output logic [N-1:0]   pc_d_o,
  output logic           cs_a_o,
  output logic           cs_b_o,
  output logic           cs_out_o,
  output logic           cs_pc_o,
  output logic           carry_o,
  output logic           halted_o
);

  state_t       state_q, state_d;
  logic         carry_q;
  logic [3:0]   opcode;
  logic [N-1:0] imm;
  logic [N-1:0] src;
  logic [N-1:0] sum;
  logic         co;
  logic         ld_a, ld_b, ld_out;
  logic         jump_taken;
  logic [N-1:0] pc_inc;

  assign opcode = op_i[N+3:N];
  assign imm    = op_i[N-1:0];
  assign pc_inc = pc_i + 1'b1;

  // Source select, destination decode and jump resolution.
  always_comb begin
    src        = '0;
    ld_a       = 1'b0;
    ld_b       = 1'b0;
    ld_out     = 1'b0;
    jump_taken = 1'b0;
    case (opcode)
      OP_ADD_A:  begin src = reg_a_i;   ld_a   = 1'b1; end
      OP_MOV_AB: begin src = reg_b_i;   ld_a   = 1'b1; end
      OP_IN_A:   begin src = in_port_i; ld_a   = 1'b1; end
      OP_MOV_A:  begin                  ld_a   = 1'b1; end
      OP_MOV_BA: begin src = reg_a_i;   ld_b   = 1'b1; end
      OP_ADD_B:  begin src = reg_b_i;   ld_b   = 1'b1; end
      OP_IN_B:   begin src = in_port_i; ld_b   = 1'b1; end
      OP_MOV_B:  begin                  ld_b   = 1'b1; end
      OP_OUT_B:  begin src = reg_b_i;   ld_out = 1'b1; end
      OP_OUT_IM: begin                  ld_out = 1'b1; end
      OP_JMP:    jump_taken = 1'b1;
      // JNC looks at the flag as it stands before this edge.
      OP_JNC:    jump_taken = ~carry_q;
      default:   ;
    endcase
  end

  td4_alu #(.N(N)) u_alu (
    .src_i (src),
    .imm_i (imm),
    .sum_o (sum),
    .co_o  (co)
  );

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      state_q <= ST_HOLD;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_RUN) carry_q <= co;
    end
  end

  always_comb begin
    state_d  = state_q;
    d_o      = '0;
    pc_d_o   = pc_i;
    cs_a_o   = 1'b1;
    cs_b_o   = 1'b1;
    cs_out_o = 1'b1;
    cs_pc_o  = 1'b1;
    case (state_q)
      ST_HOLD: state_d = ST_RUN;
      ST_RUN: begin
        d_o      = sum;
        pc_d_o   = jump_taken ? imm : pc_inc;
        cs_a_o   = ~ld_a;
        cs_b_o   = ~ld_b;
        cs_out_o = ~ld_out;
        cs_pc_o  = 1'b0;
`ifdef HALT_DETECT_EN
        // Self-jump: PC still loads (same value) while the FSM parks.
        if (jump_taken && (imm == pc_i)) state_d = ST_HALT;
`endif
      end
      default: state_d = state_q;  // ST_HALT: quiet until clr_i
    endcase
    // Keep selects inactive for the whole clear pulse, independent of state timing.
    if (clr_i) begin
      cs_a_o   = 1'b1;
      cs_b_o   = 1'b1;
      cs_out_o = 1'b1;
      cs_pc_o  = 1'b1;
    end
  end

  assign carry_o = carry_q;

`ifdef HALT_DETECT_EN
  assign halted_o = (state_q == ST_HALT);
`else
  assign halted_o = 1'b0;
`endif

endmodule

// File: tb/tb_td4_exec_unit.sv
module tb_td4_exec_unit;

  localparam int N = 4;

  logic         clk_i = 1'b0;
  logic         clr_i;
  logic [N+3:0] op_i;
  logic [N-1:0] pc_i, reg_a_i, reg_b_i, in_port_i;
  logic [N-1:0] d_o, pc_d_o;
  logic         cs_a_o, cs_b_o, cs_out_o, cs_pc_o, carry_o, halted_o;

  int n_checks = 0;
  int n_errors = 0;

  td4_exec_unit #(.N(N)) dut (
    .clk_i     (clk_i),
    .clr_i     (clr_i),
    .op_i      (op_i),
    .pc_i      (pc_i),
    .reg_a_i   (reg_a_i),
    .reg_b_i   (reg_b_i),
    .in_port_i (in_port_i),
    .d_o       (d_o),
    .pc_d_o    (pc_d_o),
    .cs_a_o    (cs_a_o),
    .cs_b_o    (cs_b_o),
    .cs_out_o  (cs_out_o),
    .cs_pc_o   (cs_pc_o),
    .carry_o   (carry_o),
    .halted_o  (halted_o)
  );

  always #5 clk_i = ~clk_i;

  // Load selects packed as {A, B, OUT, PC}, active-low.
  localparam logic [3:0] CS_NONE = 4'b1111;
  localparam logic [3:0] CS_PC   = 4'b1110;
  localparam logic [3:0] CS_A    = 4'b0110;
  localparam logic [3:0] CS_B    = 4'b1010;
  localparam logic [3:0] CS_OUT  = 4'b1100;

  function automatic logic [3:0] cs_vec();
    return {cs_a_o, cs_b_o, cs_out_o, cs_pc_o};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Apply inputs mid-cycle and let the combinational decode settle.
  task automatic apply(input logic [7:0] op, input logic [3:0] pc);
    op_i = op;
    pc_i = pc;
    #1;
  endtask

  initial begin
    clr_i = 1'b1; op_i = '0; pc_i = '0; reg_a_i = '0; reg_b_i = '0; in_port_i = '0;
    #3;
    // 1. reset / HOLD / first RUN cycle
    check("rst_cs", cs_vec(), CS_NONE);
    check("rst_carry", carry_o, 0);
    check("rst_halted", halted_o, 0);
    tick(); tick();
    check("rst_cs_clocked", cs_vec(), CS_NONE);
    clr_i = 1'b0;
    apply(8'h03, 4'h3);
    check("hold_cs", cs_vec(), CS_NONE);
    check("hold_d", d_o, 0);
    check("hold_pcd", pc_d_o, 4'h3);
    check("hold_carry", carry_o, 0);
    tick();
    apply(8'h80, 4'h3);                       // NOP
    check("run_nop_cs", cs_vec(), CS_PC);
    check("run_nop_pcd", pc_d_o, 4'h4);

    // 2. ADD A,3 with A=E -> 1, carry out
    reg_a_i = 4'hE;
    apply(8'h03, 4'h4);
    check("adda_d", d_o, 4'h1);
    check("adda_cs", cs_vec(), CS_A);
    tick();
    check("adda_carry", carry_o, 1);

    // 3. JNC with carry set falls through; carry cleared; JNC then taken
    apply(8'hE5, 4'h2);
    check("jnc_nt_pcd", pc_d_o, 4'h3);
    check("jnc_nt_cs", cs_vec(), CS_PC);
    tick();
    check("jnc_carry", carry_o, 0);
    apply(8'h30, 4'h3);                       // MOV A,0
    check("mova_d", d_o, 4'h0);
    check("mova_cs", cs_vec(), CS_A);
    tick();
    check("mova_carry", carry_o, 0);
    apply(8'hE5, 4'h2);
    check("jnc_t_pcd", pc_d_o, 4'h5);
    check("jnc_t_cs", cs_vec(), CS_PC);
    apply(8'h80, 4'hF);                       // PC wrap on increment
    check("pc_wrap", pc_d_o, 4'h0);
    tick();

    // 4. IN A, OUT Im, OUT B overflow
    in_port_i = 4'h9;
    apply(8'h21, 4'h6);
    check("ina_d", d_o, 4'hA);
    check("ina_cs", cs_vec(), CS_A);
    tick();
    apply(8'hB7, 4'h7);
    check("outim_d", d_o, 4'h7);
    check("outim_cs", cs_vec(), CS_OUT);
    tick();
    reg_b_i = 4'hF;
    apply(8'h91, 4'h8);
    check("outb_d", d_o, 4'h0);
    check("outb_cs", cs_vec(), CS_OUT);
    tick();
    check("outb_carry", carry_o, 1);

    // 6. async clear between edges while carry=1
    clr_i = 1'b1;
    #1;
    check("aclr_carry", carry_o, 0);
    check("aclr_cs", cs_vec(), CS_NONE);
    #2;
    clr_i = 1'b0;
    apply(8'h80, 4'h9);
    check("aclr_hold_cs", cs_vec(), CS_NONE);
    tick();
    apply(8'h80, 4'h9);
    check("aclr_resume_cs", cs_vec(), CS_PC);
    check("aclr_resume_pcd", pc_d_o, 4'hA);

    // B-destination paths
    reg_b_i = 4'h7;
    apply(8'h53, 4'h9);                       // ADD B,3
    check("addb_d", d_o, 4'hA);
    check("addb_cs", cs_vec(), CS_B);
    reg_a_i = 4'h6;
    apply(8'h40, 4'h9);                       // MOV B,A
    check("movba_d", d_o, 4'h6);
    check("movba_cs", cs_vec(), CS_B);
    tick();
    check("movba_carry", carry_o, 0);

    // 5. self-jump
    apply(8'hF4, 4'h4);
    check("jmp_self_pcd", pc_d_o, 4'h4);
    check("jmp_self_cs", cs_vec(), CS_PC);
    tick();
`ifdef HALT_DETECT_EN
    check("halt_flag", halted_o, 1);
    apply(8'h03, 4'h4);
    check("halt_cs", cs_vec(), CS_NONE);
    tick();
    check("halt_cs_later", cs_vec(), CS_NONE);
`else
    check("nohalt_flag", halted_o, 0);
    apply(8'hF4, 4'h4);
    check("nohalt_cs", cs_vec(), CS_PC);
    check("nohalt_pcd", pc_d_o, 4'h4);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
